// File: rtl/wb_slave_standard_if.sv
// Wishbone classic bus bundle shared by a standard master and the slave.
// Slave drives dat_s and ack; the master drives everything else.
interface if_wb #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic [AW-1:0] adr;
   logic [DW-1:0] dat_m;
   logic [DW-1:0] dat_s;
   logic          we;
   logic          cyc;
   logic          stb;
   logic          ack;

   modport slave  (input adr, dat_m, we, cyc, stb, output dat_s, ack);
   modport master (output adr, dat_m, we, cyc, stb, input dat_s, ack);
endinterface

// File: rtl/wb_slave_standard.sv
// Wishbone classic single-access slave backed by a word RAM, with a fixed
// number of wait states between the sampled request and a one-cycle ACK.
//
// Handshake: a transfer is requested while cyc & stb are high; the slave answers
// with ack high for exactly one cycle, and the master must hold adr/we/dat_m
// through the edge that ends the ack cycle. Dropping cyc or stb early aborts.
module wb_slave_standard #(
   parameter int waitcycles = 0,
   parameter int mem_aw     = 8
) (
   input  logic       clk,
   input  logic       rst,
   if_wb.slave        wb,
   output logic [1:0] dbg_state
);
   localparam int DW = $bits(wb.dat_m);
   localparam int CW = (waitcycles > 0) ? $clog2(waitcycles + 1) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t            state, state_nx;
   logic [CW-1:0]     cnt, cnt_nx;
   logic [DW-1:0]     mem [2**mem_aw];
   logic [DW-1:0]     dat_q;
   logic              ack_q;
   logic              req;
   logic [mem_aw-1:0] idx;
   logic              unused_adr;

   assign req        = wb.cyc & wb.stb;
   assign idx        = wb.adr[mem_aw-1:0];
   assign unused_adr = ^wb.adr;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (req) begin
               if (waitcycles == 0) begin
                  state_nx = ACK;
               end else begin
                  state_nx = WAIT;
                  cnt_nx   = CW'(waitcycles);
               end
            end
         end
         WAIT: begin
            // The edge that takes the count to zero is the one that enters ACK.
            if (!req) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt <= CW'(1)) begin
               state_nx = ACK;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         ACK: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         ack_q <= (state_nx == ACK);
         dat_q <= (state_nx == ACK && !wb.we) ? mem[idx] : '0;
      end
   end

   // RAM is never cleared; a reset on the ack-ending edge suppresses the write.
   always_ff @(posedge clk) begin
      if (!rst && state == ACK && req && wb.we) begin
         mem[idx] <= wb.dat_m;
      end
   end

   assign wb.ack    = ack_q;
   assign wb.dat_s  = dat_q;
   assign dbg_state = state;
endmodule

// File: tb/tb_wb_slave_standard.sv
// Drives three slaves (0, 1 and 3 wait states) from one clock and checks
// latency, read data, single ack per transfer, abort, reset and aliasing.
module tb_wb_slave_standard;
   logic clk;
   logic rst;

   logic [15:0] m_adr [3];
   logic [15:0] m_dat [3];
   logic        m_we  [3];
   logic        m_cyc [3];
   logic        m_stb [3];
   logic        s_ack [3];
   logic [15:0] s_dat [3];
   logic [1:0]  dbg0, dbg1, dbg2;

   if_wb bus0 ();
   if_wb bus1 ();
   if_wb bus2 ();

   assign bus0.adr = m_adr[0]; assign bus0.dat_m = m_dat[0]; assign bus0.we = m_we[0];
   assign bus0.cyc = m_cyc[0]; assign bus0.stb = m_stb[0];
   assign bus1.adr = m_adr[1]; assign bus1.dat_m = m_dat[1]; assign bus1.we = m_we[1];
   assign bus1.cyc = m_cyc[1]; assign bus1.stb = m_stb[1];
   assign bus2.adr = m_adr[2]; assign bus2.dat_m = m_dat[2]; assign bus2.we = m_we[2];
   assign bus2.cyc = m_cyc[2]; assign bus2.stb = m_stb[2];
   assign s_ack[0] = bus0.ack; assign s_dat[0] = bus0.dat_s;
   assign s_ack[1] = bus1.ack; assign s_dat[1] = bus1.dat_s;
   assign s_ack[2] = bus2.ack; assign s_dat[2] = bus2.dat_s;

   wb_slave_standard #(.waitcycles(0), .mem_aw(8)) dut0 (.clk(clk), .rst(rst), .wb(bus0), .dbg_state(dbg0));
   wb_slave_standard #(.waitcycles(1), .mem_aw(8)) dut1 (.clk(clk), .rst(rst), .wb(bus1), .dbg_state(dbg1));
   wb_slave_standard #(.waitcycles(3), .mem_aw(8)) dut2 (.clk(clk), .rst(rst), .wb(bus2), .dbg_state(dbg2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [15:0] adr;
      logic [15:0] dat;
      logic [15:0] exp;
      bit          b2b;
   } vec_t;

   vec_t        vecs [$];
   logic [15:0] exp_q [$];
   int          wc_tab [3];
   int          exp_acks [3];
   int          ack_cnt [3];
   int          total;
   int          bad;

   initial begin
      ack_cnt[0] = 0; ack_cnt[1] = 0; ack_cnt[2] = 0;
   end

   always @(negedge clk) begin
      if (s_ack[0]) ack_cnt[0]++;
      if (s_ack[1]) ack_cnt[1]++;
      if (s_ack[2]) ack_cnt[2]++;
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   task automatic idle_bus(input int d);
      m_cyc[d] = 1'b0; m_stb[d] = 1'b0; m_we[d] = 1'b0;
      m_adr[d] = 16'h0; m_dat[d] = 16'h0;
   endtask

   task automatic xfer(input int d, input logic we, input logic [15:0] a,
                       input logic [15:0] wd, input logic [15:0] exp, input bit b2b);
      int          n;
      bit          got;
      logic [15:0] e;
      m_cyc[d] = 1'b1; m_stb[d] = 1'b1; m_we[d] = we; m_adr[d] = a; m_dat[d] = wd;
      if (!we) exp_q.push_back(exp);
      exp_acks[d]++;
      n   = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (s_ack[d]) got = 1'b1;
      end
      total++;
      if (!got || n != wc_tab[d] + 1) begin
         bad++;
         $display("FAIL latency dut%0d adr=%h: got %0d cycles (ack=%0b) want %0d",
                  d, a, n, got, wc_tab[d] + 1);
      end
      if (!we) begin
         e = exp_q.pop_front();
         if (got) check($sformatf("rd_data dut%0d adr=%h", d, a), s_dat[d], e);
      end
      @(posedge clk); #1;
      check($sformatf("single_ack dut%0d adr=%h", d, a), {15'b0, s_ack[d]}, 16'd0);
      if (!b2b) begin
         idle_bus(d);
         @(posedge clk); #1;
         check($sformatf("idle_ack dut%0d", d), {15'b0, s_ack[d]}, 16'd0);
         check($sformatf("idle_dat dut%0d", d), s_dat[d], 16'd0);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      wc_tab[0] = 0; wc_tab[1] = 1; wc_tab[2] = 3;
      for (int d = 0; d < 3; d++) begin
         exp_acks[d] = 0;
         idle_bus(d);
      end

      for (int i = 1; i <= 10; i++)
         vecs.push_back('{we: 1'b1, adr: 16'(i), dat: 16'(100 + i), exp: 16'd0, b2b: 1'b0});
      for (int i = 1; i <= 10; i++)
         vecs.push_back('{we: 1'b0, adr: 16'(i), dat: 16'd0, exp: 16'(100 + i), b2b: 1'b0});
      for (int i = 11; i <= 20; i++)
         vecs.push_back('{we: 1'b1, adr: 16'(i), dat: 16'(200 + i), exp: 16'd0, b2b: (i != 20)});
      for (int i = 11; i <= 20; i++)
         vecs.push_back('{we: 1'b0, adr: 16'(i), dat: 16'd0, exp: 16'(200 + i), b2b: (i != 20)});

      rst = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_ack dut%0d", d), {15'b0, s_ack[d]}, 16'd0);
            check($sformatf("rst_dat dut%0d", d), s_dat[d], 16'd0);
         end
      end
      rst = 1'b0;
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++)
         check($sformatf("post_rst_ack dut%0d", d), {15'b0, s_ack[d]}, 16'd0);

      for (int d = 0; d < 3; d++)
         for (int v = 0; v < vecs.size(); v++)
            xfer(d, vecs[v].we, vecs[v].adr, vecs[v].dat, vecs[v].exp, vecs[v].b2b);

      // abort: write dropped after two cycles in the 3-wait slave
      m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b1; m_adr[2] = 16'd5; m_dat[2] = 16'd999;
      repeat (2) begin
         @(posedge clk); #1;
         check("abort_no_ack_held", {15'b0, s_ack[2]}, 16'd0);
      end
      idle_bus(2);
      repeat (4) begin
         @(posedge clk); #1;
         check("abort_no_ack_after", {15'b0, s_ack[2]}, 16'd0);
      end
      xfer(2, 1'b0, 16'd5, 16'd0, 16'd105, 1'b0);

      // reset during the ack cycle of a write cancels the write
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_adr[0] = 16'd8; m_dat[0] = 16'd555;
      exp_acks[0]++;
      @(posedge clk); #1;
      check("rst_in_ack_ack_seen", {15'b0, s_ack[0]}, 16'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ack_ack_gone", {15'b0, s_ack[0]}, 16'd0);
      rst = 1'b0;
      idle_bus(0);
      @(posedge clk); #1;
      xfer(0, 1'b0, 16'd8, 16'd0, 16'd108, 1'b0);

      // address aliasing modulo 256
      xfer(0, 1'b1, 16'h0103, 16'd77, 16'd0, 1'b0);
      xfer(0, 1'b0, 16'h0003, 16'd0, 16'd77, 1'b0);
      xfer(0, 1'b0, 16'h0203, 16'd0, 16'd77, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++)
         check($sformatf("ack_count dut%0d", d), 16'(ack_cnt[d]), 16'(exp_acks[d]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
